write_through_buffer: RTL and testbench

Write-through buffer between the cache front-end's registered request stage and the back-end memory port. It queues up to 2^WB_DEPTH_W word writes (address, data, byte strobe) and drains them one at a time over a valid/ready handshake. It reports empty, full, level and overflow so cache control can stall writes and order reads behind pending writes.

---
 rtl/write_through_buffer_pkg.sv | 28 ++
 rtl/write_through_buffer_wb_regfile.sv | 44 ++++
 rtl/write_through_buffer.sv | 173 +++++++++++++++++
 tb/tb_write_through_buffer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/write_through_buffer_pkg.sv
//==============================================================================
// Module      : write_through_buffer_pkg
// Description : Shared types for the write-through buffer: back-end FSM state
//               encodings and an entry-width helper.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package write_through_buffer_pkg;

  // Back-end request FSM states
  typedef enum logic [0:0] {
    WB_IDLE  = 1'b0,
    WB_WRITE = 1'b1
  } wb_state_e;

  // Width of one stored entry: word address + data + byte strobes
  function automatic int unsigned wb_entry_width(
    input int unsigned addr_w,
    input int unsigned data_w,
    input int unsigned nbytes
  );
    return addr_w + data_w + nbytes;
  endfunction

endpackage

`default_nettype wire

// File: rtl/write_through_buffer_wb_regfile.sv
//==============================================================================
// Module      : wb_regfile
// Description : Entry storage for the write-through buffer. One synchronous
//               write port, two combinational read ports at raddr and
//               raddr+1 (modulo depth) so the back-end can prefetch the next
//               entry in the same cycle the current one is accepted.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module wb_regfile #(
  parameter int unsigned ENTRY_W = 64,
  parameter int unsigned DEPTH_W = 2
) (
  input  logic               clk,
  input  logic               we,
  input  logic [DEPTH_W-1:0] waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [DEPTH_W-1:0] raddr,
  output logic [ENTRY_W-1:0] rdata0,
  output logic [ENTRY_W-1:0] rdata1
);

  localparam int unsigned DEPTH = 1 << DEPTH_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [DEPTH_W-1:0] w_raddr_next;

  // Wraps naturally because the pointer width equals log2(depth)
  assign w_raddr_next = raddr + DEPTH_W'(1);

  // Array contents carry no reset; validity is tracked by the level counter
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata0 = mem_q[raddr];
  assign rdata1 = mem_q[w_raddr_next];

endmodule

`default_nettype wire

// File: rtl/write_through_buffer.sv
//==============================================================================
// Module      : write_through_buffer
// Description : Queues word writes from the cache front-end and drains them in
//               order to the back-end memory port over valid/ready. An entry
//               stays counted in the level until memory accepts it, so
//               wb_empty means every write has landed.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module write_through_buffer
  import write_through_buffer_pkg::*;
#(
  parameter int unsigned FE_ADDR_W  = 32,
  parameter int unsigned FE_DATA_W  = 32,
  parameter int unsigned FE_NBYTES  = FE_DATA_W / 8,
  parameter int unsigned FE_BYTE_W  = $clog2(FE_NBYTES),
  parameter int unsigned WB_DEPTH_W = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           wb_push,
  input  logic [FE_ADDR_W-FE_BYTE_W-1:0] wb_addr,
  input  logic [FE_DATA_W-1:0]           wb_wdata,
  input  logic [FE_NBYTES-1:0]           wb_wstrb,
  output logic                           wb_full,
  output logic                           wb_empty,
  output logic [WB_DEPTH_W:0]            wb_level,
  output logic                           wb_overflow,
  output logic                           mem_valid,
  output logic [FE_ADDR_W-1:0]           mem_addr,
  output logic [FE_DATA_W-1:0]           mem_wdata,
  output logic [FE_NBYTES-1:0]           mem_wstrb,
  input  logic                           mem_ready
);

  localparam int unsigned WORD_AW = FE_ADDR_W - FE_BYTE_W;
  localparam int unsigned ENTRY_W = wb_entry_width(WORD_AW, FE_DATA_W, FE_NBYTES);
  localparam logic [WB_DEPTH_W:0] FULL_LEVEL = (WB_DEPTH_W + 1)'(1 << WB_DEPTH_W);
  localparam logic [WB_DEPTH_W:0] LEVEL_ONE  = (WB_DEPTH_W + 1)'(1);
  localparam logic [WB_DEPTH_W:0] LEVEL_TWO  = (WB_DEPTH_W + 1)'(2);
  localparam logic [WB_DEPTH_W-1:0] PTR_ONE  = WB_DEPTH_W'(1);

  // Queue bookkeeping
  logic [WB_DEPTH_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [WB_DEPTH_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [WB_DEPTH_W:0]   level_q, level_d;
  logic                  overflow_q, overflow_d;

  // Back-end FSM and registered request payload
  wb_state_e             state_q, state_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [WORD_AW-1:0]    mem_addr_q, mem_addr_d;
  logic [FE_DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
  logic [FE_NBYTES-1:0]  mem_wstrb_q, mem_wstrb_d;

  logic                  w_full;
  logic                  w_push_ok;
  logic                  w_pop;
  logic [ENTRY_W-1:0]    w_push_entry;
  logic [ENTRY_W-1:0]    w_rd_entry0;
  logic [ENTRY_W-1:0]    w_rd_entry1;

  // Full comes from the registered level only, so a pop in the same cycle
  // never makes room for a push; this keeps wb_push off any output path.
  assign w_full       = (level_q == FULL_LEVEL);
  assign w_push_ok    = wb_push & ~w_full;
  assign w_pop        = mem_valid_q & mem_ready;
  assign w_push_entry = {wb_addr, wb_wdata, wb_wstrb};

  wb_regfile #(
    .ENTRY_W (ENTRY_W),
    .DEPTH_W (WB_DEPTH_W)
  ) u_regfile (
    .clk    (clk),
    .we     (w_push_ok),
    .waddr  (wr_ptr_q),
    .wdata  (w_push_entry),
    .raddr  (rd_ptr_q),
    .rdata0 (w_rd_entry0),
    .rdata1 (w_rd_entry1)
  );

  // Pointer, level and sticky overflow next-state
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q | (wb_push & w_full);
    if (w_push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (w_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({w_push_ok, w_pop})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  // Back-end FSM: issue the head entry, and on acceptance prefetch the next
  // one (rd_ptr+1) so a full queue drains without bubbles.
  always_comb begin
    state_d     = state_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      WB_IDLE: begin
        if (level_q != '0) begin
          state_d     = WB_WRITE;
          mem_valid_d = 1'b1;
          {mem_addr_d, mem_wdata_d, mem_wstrb_d} = w_rd_entry0;
        end
      end
      WB_WRITE: begin
        if (mem_ready) begin
          if (level_q >= LEVEL_TWO) begin
            {mem_addr_d, mem_wdata_d, mem_wstrb_d} = w_rd_entry1;
          end else begin
            // A push landing this cycle is issued from idle next cycle
            state_d     = WB_IDLE;
            mem_valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d     = WB_IDLE;
        mem_valid_d = 1'b0;
      end
    endcase
  end

  // All state registers; reset discards queued and in-flight writes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      state_q     <= WB_IDLE;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      state_q     <= state_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

  assign wb_full     = w_full;
  assign wb_empty    = (level_q == '0);
  assign wb_level    = level_q;
  assign wb_overflow = overflow_q;
  assign mem_valid   = mem_valid_q;
  assign mem_addr    = {mem_addr_q, {FE_BYTE_W{1'b0}}};
  assign mem_wdata   = mem_wdata_q;
  assign mem_wstrb   = mem_wstrb_q;

endmodule

`default_nettype wire

// File: tb/tb_write_through_buffer.sv
//==============================================================================
// Module      : tb_write_through_buffer
// Description : Directed bench for write_through_buffer: a vector table for
//               single write, fill/overflow and drain, then hand sequences
//               for wrap-around, push+pop at level 2 and asynchronous reset.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_write_through_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_push;
  logic [29:0] wb_addr;
  logic [31:0] wb_wdata;
  logic [3:0]  wb_wstrb;
  logic        wb_full;
  logic        wb_empty;
  logic [2:0]  wb_level;
  logic        wb_overflow;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  write_through_buffer dut (
    .clk         (clk),
    .reset       (reset),
    .wb_push     (wb_push),
    .wb_addr     (wb_addr),
    .wb_wdata    (wb_wdata),
    .wb_wstrb    (wb_wstrb),
    .wb_full     (wb_full),
    .wb_empty    (wb_empty),
    .wb_level    (wb_level),
    .wb_overflow (wb_overflow),
    .mem_valid   (mem_valid),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_wstrb   (mem_wstrb),
    .mem_ready   (mem_ready)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic        push;
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ready;
    logic        e_valid;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [2:0]  e_level;
    logic        e_full;
    logic        e_empty;
    logic        e_ovf;
  } vec_t;

  typedef logic [65:0] ent_t;

  vec_t vecs [13];

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    ent_t q[$];
    ent_t e;
    int   pushes;
    int   hs;
    bit   done;

    // Each row: inputs for one edge, outputs expected after that edge
    vecs[0]  = '{1'b1, 30'h1234, 32'hDEADBEEF, 4'hF, 1'b1, 1'b0, 32'h0,    32'h0,        4'h0, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 30'h0,    32'h0,        4'h0, 1'b1, 1'b1, 32'h48D0, 32'hDEADBEEF, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 30'h0,    32'h0,        4'h0, 1'b1, 1'b0, 32'h48D0, 32'hDEADBEEF, 4'hF, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 30'h10,   32'h11111111, 4'h1, 1'b0, 1'b0, 32'h48D0, 32'hDEADBEEF, 4'hF, 3'd1, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 30'h11,   32'h22222222, 4'h3, 1'b0, 1'b1, 32'h40,   32'h11111111, 4'h1, 3'd2, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 30'h12,   32'h33333333, 4'h7, 1'b0, 1'b1, 32'h40,   32'h11111111, 4'h1, 3'd3, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 30'h13,   32'h44444444, 4'h0, 1'b0, 1'b1, 32'h40,   32'h11111111, 4'h1, 3'd4, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 30'h14,   32'h55555555, 4'hF, 1'b0, 1'b1, 32'h40,   32'h11111111, 4'h1, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 30'h0,    32'h0,        4'h0, 1'b0, 1'b1, 32'h40,   32'h11111111, 4'h1, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 30'h14,   32'h55555555, 4'hF, 1'b1, 1'b1, 32'h44,   32'h22222222, 4'h3, 3'd3, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 30'h0,    32'h0,        4'h0, 1'b1, 1'b1, 32'h48,   32'h33333333, 4'h7, 3'd2, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 30'h0,    32'h0,        4'h0, 1'b1, 1'b1, 32'h4C,   32'h44444444, 4'h0, 3'd1, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 30'h0,    32'h0,        4'h0, 1'b1, 1'b0, 32'h4C,   32'h44444444, 4'h0, 3'd0, 1'b0, 1'b1, 1'b1};

    reset     = 1'b0;
    wb_push   = 1'b0;
    wb_addr   = '0;
    wb_wdata  = '0;
    wb_wstrb  = '0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);

    check("rst_valid", 64'(mem_valid), 64'd0);
    check("rst_addr",  64'(mem_addr),  64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    check("rst_wstrb", 64'(mem_wstrb), 64'd0);
    check("rst_empty", 64'(wb_empty),  64'd1);
    check("rst_full",  64'(wb_full),   64'd0);
    check("rst_level", 64'(wb_level),  64'd0);
    check("rst_ovf",   64'(wb_overflow), 64'd0);
    reset = 1'b1;

    // ---------------- table: single write, fill, overflow, drain -----------
    for (int i = 0; i < 13; i++) begin
      wb_push   = vecs[i].push;
      wb_addr   = vecs[i].addr;
      wb_wdata  = vecs[i].wdata;
      wb_wstrb  = vecs[i].wstrb;
      mem_ready = vecs[i].ready;
      @(negedge clk);
      check($sformatf("v%0d_valid", i), 64'(mem_valid),   64'(vecs[i].e_valid));
      check($sformatf("v%0d_addr", i),  64'(mem_addr),    64'(vecs[i].e_addr));
      check($sformatf("v%0d_wdata", i), 64'(mem_wdata),   64'(vecs[i].e_wdata));
      check($sformatf("v%0d_wstrb", i), 64'(mem_wstrb),   64'(vecs[i].e_wstrb));
      check($sformatf("v%0d_level", i), 64'(wb_level),    64'(vecs[i].e_level));
      check($sformatf("v%0d_full", i),  64'(wb_full),     64'(vecs[i].e_full));
      check($sformatf("v%0d_empty", i), 64'(wb_empty),    64'(vecs[i].e_empty));
      check($sformatf("v%0d_ovf", i),   64'(wb_overflow), 64'(vecs[i].e_ovf));
    end
    wb_push   = 1'b0;
    mem_ready = 1'b0;

    // ---------------- wrap-around with a scoreboard --------------------------
    pushes = 0;
    hs     = 0;
    done   = 1'b0;
    for (int c = 0; c < 200 && !done; c++) begin
      check("wrap_level", 64'(wb_level), 64'(q.size()));
      wb_push   = 1'b0;
      mem_ready = ((c % 3) != 0);
      if (pushes < 10 && q.size() < 3 && (c % 4) != 3) begin
        wb_push  = 1'b1;
        wb_addr  = 30'h100 + 30'(pushes);
        wb_wdata = 32'hA5000000 | 32'(pushes);
        wb_wstrb = 4'(pushes);
      end
      if (mem_valid && mem_ready) begin
        if (q.size() == 0) begin
          check("wrap_spurious", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          check("wrap_addr",  64'(mem_addr),  64'({e[65:36], 2'b00}));
          check("wrap_wdata", 64'(mem_wdata), 64'(e[35:4]));
          check("wrap_wstrb", 64'(mem_wstrb), 64'(e[3:0]));
        end
        hs++;
      end
      if (wb_push) begin
        q.push_back({wb_addr, wb_wdata, wb_wstrb});
        pushes++;
      end
      @(negedge clk);
      if (pushes == 10 && q.size() == 0) done = 1'b1;
    end
    wb_push   = 1'b0;
    mem_ready = 1'b0;
    check("wrap_done",       64'(done),     64'd1);
    check("wrap_handshakes", 64'(hs),       64'd10);
    @(negedge clk);
    check("wrap_empty",      64'(wb_empty), 64'd1);
    check("wrap_idle",       64'(mem_valid), 64'd0);

    // ---------------- simultaneous push and pop at level 2 -------------------
    wb_push = 1'b1; wb_addr = 30'h200; wb_wdata = 32'hC0000001; wb_wstrb = 4'hF; mem_ready = 1'b0;
    @(negedge clk);
    check("sim_level1", 64'(wb_level), 64'd1);
    wb_addr = 30'h201; wb_wdata = 32'hC0000002; wb_wstrb = 4'h5;
    @(negedge clk);
    check("sim_level2", 64'(wb_level),  64'd2);
    check("sim_addr1",  64'(mem_addr),  64'h800);
    check("sim_data1",  64'(mem_wdata), 64'hC0000001);
    wb_addr = 30'h202; wb_wdata = 32'hC0000003; wb_wstrb = 4'hA; mem_ready = 1'b1;
    @(negedge clk);
    check("sim_level_hold", 64'(wb_level),  64'd2);
    check("sim_addr2",      64'(mem_addr),  64'h804);
    check("sim_data2",      64'(mem_wdata), 64'hC0000002);
    check("sim_strb2",      64'(mem_wstrb), 64'h5);
    wb_push = 1'b0;
    @(negedge clk);
    check("sim_level3", 64'(wb_level),  64'd1);
    check("sim_addr3",  64'(mem_addr),  64'h808);
    check("sim_data3",  64'(mem_wdata), 64'hC0000003);
    check("sim_strb3",  64'(mem_wstrb), 64'hA);
    @(negedge clk);
    check("sim_done_valid", 64'(mem_valid), 64'd0);
    check("sim_done_empty", 64'(wb_empty),  64'd1);
    mem_ready = 1'b0;

    // ---------------- reset in the middle of a drain -------------------------
    for (int i = 0; i < 5; i++) begin
      wb_push  = 1'b1;
      wb_addr  = 30'h300 + 30'(i);
      wb_wdata = 32'hF0000000 | 32'(i);
      wb_wstrb = 4'hF;
      @(negedge clk);
    end
    check("rm_full", 64'(wb_level),    64'd4);
    check("rm_ovf",  64'(wb_overflow), 64'd1);
    wb_push   = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    check("rm_level3", 64'(wb_level),  64'd3);
    check("rm_valid",  64'(mem_valid), 64'd1);
    check("rm_data",   64'(mem_wdata), 64'hF0000001);
    #2 reset = 1'b0;
    #1;
    check("rm_async_valid", 64'(mem_valid),   64'd0);
    check("rm_async_level", 64'(wb_level),    64'd0);
    check("rm_async_empty", 64'(wb_empty),    64'd1);
    check("rm_async_ovf",   64'(wb_overflow), 64'd0);
    check("rm_async_addr",  64'(mem_addr),    64'd0);
    @(negedge clk);
    reset    = 1'b1;
    wb_push  = 1'b1;
    wb_addr  = 30'h3FF;
    wb_wdata = 32'h12345678;
    wb_wstrb = 4'h9;
    mem_ready = 1'b1;
    @(negedge clk);
    wb_push = 1'b0;
    check("rp_level", 64'(wb_level),  64'd1);
    check("rp_valid0", 64'(mem_valid), 64'd0);
    @(negedge clk);
    check("rp_valid", 64'(mem_valid), 64'd1);
    check("rp_addr",  64'(mem_addr),  64'hFFC);
    check("rp_data",  64'(mem_wdata), 64'h12345678);
    check("rp_strb",  64'(mem_wstrb), 64'h9);
    @(negedge clk);
    check("rp_drained", 64'(wb_empty),  64'd1);
    check("rp_idle",    64'(mem_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
